multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised multicycle MIPS control unit driving the existing datapath muxes and write enables: PC, IR, A/B, register file, memory and ALU. It is the successor to the fixed three-state fetch controller. It adds a configurable memory wait depth, instruction decode, and execute/writeback sequences for R-type (add/sub/and/xor), lw, sw, beq and j. All outputs are a pure decode of the registered state plus the wait counter, with no X values in any state.

## Interface
- MEM_WAIT, default 2: memory latency in cycles between the address being presented and read data being valid; range 0–7.
- clock  in  1  system clock; all state changes occur on the rising edge.
- reset  in  1  reset, asynchronous, active-high; clock clock.
- opcode  in  6  IR[31:26]; sampled only in DECODE.
- funct  in  6  IR[5:0]; sampled only in EXEC_R.
- zero  in  1  ALU zero flag; used only in BRANCH.
- pc_write, pc_write_cond, iord, mem_write, mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, a_write, b_write  out  1 each  datapath controls.
- pc_source  out  2  select: 00 ALU result, 01 ALUOut, 10 jump target.
- alu_src_b  out  2  select: 00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 2.
- alu_op  out  3  ALU operation: LOAD=0, ADD=1, SUB=2, AND=3, INC=4, NEG=5, XOR=6, COMP=7.
- state_out  out  4  current state code, for debug.
- trap  out  1  illegal-instruction flag (see Configuration).

## Operation
- State codes: FETCH=0, IR_LOAD=1, DECODE=2, EXEC_R=3, R_WB=4, ADDR=5, LW_MEM=6, LW_WB=7, SW_MEM=8, BRANCH=9, JUMP=10, TRAP=15.
- Defaults in every state: all 1-bit controls are 0, pc_source=00, alu_src_b=00, alu_op=LOAD, trap=0. Each state below lists only the outputs it changes from these defaults.
- FETCH: iord=0 (read from PC); alu_src_b=01; alu_op=ADD. The state is held while wait_cnt < MEM_WAIT, then moves to IR_LOAD.
- IR_LOAD: ir_write=1, pc_write=1, alu_src_b=01, alu_op=ADD, pc_source=00, so PC becomes PC+4. Next state is DECODE.
- DECODE: a_write=1, b_write=1, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 → EXEC_R
  - 0x23 or 0x2B → ADDR
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - any other opcode → illegal handling (see Configuration)
- EXEC_R: alu_src_a=1, alu_src_b=00. funct selects the ALU op: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x26 XOR. Next state is R_WB. An unknown funct is treated as an illegal instruction.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state is FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next state is LW_MEM for opcode 0x23 and SW_MEM for 0x2B; opcode is held stable by the IR.
- LW_MEM: iord=1. The state is held while wait_cnt < MEM_WAIT, then moves to LW_WB.
- LW_WB: reg_write=1, reg_dst=0, mem_to_reg=1, iord=1. Next state is FETCH.
- SW_MEM: iord=1, mem_write=1 for exactly one cycle. Next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_write_cond=1, pc_source=01. Next state is FETCH. The datapath gates the PC write with zero; this block does not use zero internally.
- JUMP: pc_write=1, pc_source=10. Next state is FETCH.
- wait_cnt: clears to 0 on entry to FETCH and on entry to LW_MEM, and increments each cycle spent in those states. With MEM_WAIT=0 each of those states lasts exactly one cycle. The counter never wraps because it is bounded by MEM_WAIT.

## Timing
- Reset (asynchronous) forces state=FETCH and wait_cnt=0. The resulting outputs are: alu_src_b=01, alu_op=ADD, state_out=0, and every other output 0. No write enable is asserted during reset or in the first FETCH cycle.
- Reset asserted mid-instruction aborts that instruction immediately. No partial write is issued after reset deasserts.
- Instruction latency in cycles, with F = MEM_WAIT+1:
  - R-type: F+4
  - lw: 2F+4
  - sw: F+4
  - beq: F+3
  - j: F+3
- With the default MEM_WAIT=2: R-type=7, lw=10, sw=7, beq=6, j=6.
- Exactly one PC write (pc_write or pc_write_cond) occurs per completed branch or jump, in addition to the PC+4 write in IR_LOAD.

## Configuration
- ILLEGAL_TRAP_EN defined: an illegal opcode or funct sends the controller to TRAP.
  - TRAP asserts trap=1 and all writes=0.
  - TRAP is held until reset; there is no other exit.
- ILLEGAL_TRAP_EN undefined:
  - An illegal instruction returns to FETCH the next cycle as a NOP, with no register or memory write.
  - trap is tied to 0, and TRAP is unreachable.

## Test plan
- Reset, then opcode=0x00 and funct=0x20 with MEM_WAIT=2 → state_out sequence 0,0,0,1,2,3,4,0; reg_write=1 only in state 4; alu_op=ADD in state 3.
- lw (opcode 0x23), MEM_WAIT=2 → sequence 0,0,0,1,2,5,6,6,6,7,0; iord=1 in states 6 and 7; mem_to_reg=1 in state 7.
- sw (opcode 0x2B) with MEM_WAIT=0 → sequence 0,1,2,5,8,0; mem_write high for exactly 1 cycle.
- beq (opcode 0x04) → pc_write_cond=1, alu_op=SUB, pc_source=01 in BRANCH only; j (opcode 0x02) → pc_write=1, pc_source=10 in JUMP.
- opcode=0x3F → with ILLEGAL_TRAP_EN, state_out=15 and trap=1 held for 20 cycles, then cleared by reset; without the macro, the next state is FETCH and no write is asserted.
- Reset asserted in LW_MEM → state_out goes to 0 immediately, without waiting for a clock edge; reg_write never asserts for the aborted load.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
// Bundle of control signals between the multicycle MIPS controller and the
// datapath it steers.
//
// Signals:
//   opcode, funct, zero       datapath -> controller (IR fields, ALU zero flag)
//   pc_write .. b_write       controller -> datapath, 1-bit enables/selects
//   pc_source, alu_src_b      controller -> datapath, mux selects
//   alu_op                    controller -> datapath, ALU operation
//   state_out, trap           controller -> observer, debug state and illegal flag
//
// Modports:
//   master  controller side
//   slave   datapath side
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_write;
  logic       mem_to_reg;
  logic       ir_write;
  logic       alu_src_a;
  logic       reg_write;
  logic       reg_dst;
  logic       a_write;
  logic       b_write;
  logic [1:0] pc_source;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state_out;
  logic       trap;

  modport master (
    input  opcode, funct, zero,
    output pc_write, pc_write_cond, iord, mem_write, mem_to_reg, ir_write,
           alu_src_a, reg_write, reg_dst, a_write, b_write,
           pc_source, alu_src_b, alu_op, state_out, trap
  );

  modport slave (
    output opcode, funct, zero,
    input  pc_write, pc_write_cond, iord, mem_write, mem_to_reg, ir_write,
           alu_src_a, reg_write, reg_dst, a_write, b_write,
           pc_source, alu_src_b, alu_op, state_out, trap
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multicycle MIPS control unit: fetch with configurable memory wait depth,
// decode, and execute/writeback sequences for R-type (add/sub/and/xor),
// lw, sw, beq and j.
//
// Parameters:
//   MEM_WAIT  memory latency in cycles (0..7); FETCH and LW_MEM each last
//             MEM_WAIT+1 cycles.
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   bus    multicycle_ctrl_if.master: opcode/funct/zero in, datapath controls,
//          state_out and trap out
//
// Build option:
//   ILLEGAL_TRAP_EN  when defined, an illegal opcode or funct parks the
//                    controller in TRAP (trap=1) until reset. When undefined,
//                    an illegal instruction retires as a NOP back to FETCH and
//                    trap is tied to 0.
//
// State table:
//   state   | meaning
//   FETCH   | present PC to memory, wait MEM_WAIT cycles for read data
//   IR_LOAD | latch instruction, PC <= PC+4
//   DECODE  | load A/B, compute branch target into ALUOut, dispatch on opcode
//   EXEC_R  | R-type ALU operation selected by funct
//   R_WB    | write ALU result to rd
//   ADDR    | compute effective address base+imm
//   LW_MEM  | present data address, wait MEM_WAIT cycles
//   LW_WB   | write loaded data to rt
//   SW_MEM  | single-cycle memory write
//   BRANCH  | compare A-B, conditional PC write with branch target
//   JUMP    | PC <= jump target
//   TRAP    | illegal instruction, held until reset
module multicycle_ctrl #(
  parameter int MEM_WAIT = 2
) (
  input  logic              clock,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    IR_LOAD = 4'd1,
    DECODE  = 4'd2,
    EXEC_R  = 4'd3,
    R_WB    = 4'd4,
    ADDR    = 4'd5,
    LW_MEM  = 4'd6,
    LW_WB   = 4'd7,
    SW_MEM  = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    TRAP    = 4'd15
  } state_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [2:0] ALU_LOAD = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd6;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

`ifdef ILLEGAL_TRAP_EN
  localparam state_t ILLEGAL_NEXT = TRAP;
`else
  localparam state_t ILLEGAL_NEXT = FETCH;
`endif

  state_t     state;
  state_t     state_next;
  logic [2:0] wait_cnt;
  logic       wait_done;
  // Load/store direction captured in DECODE so ADDR does not depend on
  // opcode being stable afterwards.
  logic       is_load;
  logic       fn_legal;
  logic [2:0] fn_alu_op;

  assign wait_done = !(wait_cnt < WAIT_LAST);

  always_comb begin
    fn_legal  = 1'b1;
    fn_alu_op = ALU_LOAD;
    case (bus.funct)
      FN_ADD:  fn_alu_op = ALU_ADD;
      FN_SUB:  fn_alu_op = ALU_SUB;
      FN_AND:  fn_alu_op = ALU_AND;
      FN_XOR:  fn_alu_op = ALU_XOR;
      default: fn_legal  = 1'b0;
    endcase
  end

  // State register, wait counter and load/store flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= FETCH;
      wait_cnt <= 3'd0;
      is_load  <= 1'b0;
    end else begin
      state <= state_next;
      // Counts only while a wait state is held; any entry into FETCH or
      // LW_MEM therefore starts from zero.
      if ((state == FETCH || state == LW_MEM) && state_next == state)
        wait_cnt <= wait_cnt + 3'd1;
      else
        wait_cnt <= 3'd0;
      if (state == DECODE)
        is_load <= (bus.opcode == OP_LW);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      FETCH:   if (wait_done) state_next = IR_LOAD;
      IR_LOAD: state_next = DECODE;
      DECODE: begin
        case (bus.opcode)
          OP_R:         state_next = EXEC_R;
          OP_LW, OP_SW: state_next = ADDR;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          default:      state_next = ILLEGAL_NEXT;
        endcase
      end
      EXEC_R:  state_next = fn_legal ? R_WB : ILLEGAL_NEXT;
      R_WB:    state_next = FETCH;
      ADDR:    state_next = is_load ? LW_MEM : SW_MEM;
      LW_MEM:  if (wait_done) state_next = LW_WB;
      LW_WB:   state_next = FETCH;
      SW_MEM:  state_next = FETCH;
      BRANCH:  state_next = FETCH;
      JUMP:    state_next = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP:    state_next = TRAP;
`else
      TRAP:    state_next = FETCH;
`endif
      default: state_next = FETCH;
    endcase
  end

  // Output decode.
  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.ir_write      = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.a_write       = 1'b0;
    bus.b_write       = 1'b0;
    bus.pc_source     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.alu_op        = ALU_LOAD;
    bus.trap          = 1'b0;
    bus.state_out     = state;
    case (state)
      FETCH: begin
        bus.alu_src_b = 2'b01;
        bus.alu_op    = ALU_ADD;
      end
      IR_LOAD: begin
        bus.ir_write  = 1'b1;
        bus.pc_write  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = ALU_ADD;
      end
      DECODE: begin
        bus.a_write   = 1'b1;
        bus.b_write   = 1'b1;
        bus.alu_src_b = 2'b11;
        bus.alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = fn_alu_op;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = ALU_ADD;
      end
      LW_MEM: bus.iord = 1'b1;
      LW_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.iord       = 1'b1;
      end
      SW_MEM: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = 2'b01;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: bus.trap = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
// Scoreboard bench for multicycle_ctrl. Each issued instruction is expanded
// into its per-cycle expected state/control sequence from the instruction's
// phase lengths; a monitor on the falling edge pops and compares one entry
// per cycle.
module tb_multicycle_ctrl;
  localparam int TB_WAIT   = 2;
  localparam int F         = TB_WAIT + 1;
  localparam int TRAP_HOLD = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_WAIT(TB_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  st;
    logic [18:0] ctl;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_pushed  = 0;
  int   n_illegal = 0;
  logic [5:0] fns [4] = '{6'h20, 6'h22, 6'h24, 6'h26};
  logic [5:0] ops [5] = '{6'h00, 6'h02, 6'h04, 6'h23, 6'h2B};

  // Expected controls for a state, packed as
  // {pc_write, pc_write_cond, iord, mem_write, mem_to_reg, ir_write,
  //  alu_src_a, reg_write, reg_dst, a_write, b_write,
  //  pc_source, alu_src_b, alu_op, trap}
  function automatic logic [18:0] ctl_of(input int st, input logic [5:0] fn);
    logic pw, pwc, io, mw, m2r, irw, asa, rw, rd, aw, bw, tr;
    logic [1:0] ps, asb;
    logic [2:0] op;
    {pw, pwc, io, mw, m2r, irw, asa, rw, rd, aw, bw, tr} = '0;
    ps = 2'b00; asb = 2'b00; op = 3'd0;
    case (st)
      0:  begin asb = 2'b01; op = 3'd1; end
      1:  begin irw = 1; pw = 1; asb = 2'b01; op = 3'd1; end
      2:  begin aw = 1; bw = 1; asb = 2'b11; op = 3'd1; end
      3: begin
        asa = 1;
        case (fn)
          6'h20:   op = 3'd1;
          6'h22:   op = 3'd2;
          6'h24:   op = 3'd3;
          6'h26:   op = 3'd6;
          default: op = 3'd0;
        endcase
      end
      4:  begin rw = 1; rd = 1; end
      5:  begin asa = 1; asb = 2'b10; op = 3'd1; end
      6:  io = 1;
      7:  begin rw = 1; m2r = 1; io = 1; end
      8:  begin io = 1; mw = 1; end
      9:  begin asa = 1; op = 3'd2; pwc = 1; ps = 2'b01; end
      10: begin pw = 1; ps = 2'b10; end
      15: tr = 1;
      default: ;
    endcase
    return {pw, pwc, io, mw, m2r, irw, asa, rw, rd, aw, bw, ps, asb, op, tr};
  endfunction

  function automatic logic [18:0] ctl_dut();
    return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_write,
            bus.mem_to_reg, bus.ir_write, bus.alu_src_a, bus.reg_write,
            bus.reg_dst, bus.a_write, bus.b_write, bus.pc_source,
            bus.alu_src_b, bus.alu_op, bus.trap};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic push(input int st, input logic [5:0] fn, input int times);
    for (int i = 0; i < times; i++) begin
      sb_q.push_back(exp_t'({4'(st), ctl_of(st, fn)}));
      n_pushed++;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Asserted mid-cycle: outputs must fall back to FETCH without a clock edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_state"}, bus.state_out, 0);
    check({tag, "_ctl"}, ctl_dut(), ctl_of(0, 6'h00));
    run_cycles(2);
    reset = 1'b0;
  endtask

  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn);
    int start;
    bit ill;
    start = n_pushed;
    ill = 1'b0;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = 1'($urandom_range(0, 1));
    push(0, fn, F);
    push(1, fn, 1);
    push(2, fn, 1);
    case (op)
      6'h00: begin
        push(3, fn, 1);
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h26}) push(4, fn, 1);
        else ill = 1'b1;
      end
      6'h23: begin push(5, fn, 1); push(6, fn, F); push(7, fn, 1); end
      6'h2B: begin push(5, fn, 1); push(8, fn, 1); end
      6'h04: push(9, fn, 1);
      6'h02: push(10, fn, 1);
      default: ill = 1'b1;
    endcase
    n_illegal += int'(ill);
`ifdef ILLEGAL_TRAP_EN
    if (ill) push(15, fn, TRAP_HOLD);
`endif
    run_cycles(n_pushed - start);
`ifdef ILLEGAL_TRAP_EN
    if (ill) do_reset("trap_clear");
`endif
  endtask

  function automatic logic [5:0] rand_illegal_op();
    logic [5:0] v;
    do v = 6'($urandom); while (v inside {6'h00, 6'h02, 6'h04, 6'h23, 6'h2B});
    return v;
  endfunction

  function automatic logic [5:0] rand_illegal_fn();
    logic [5:0] v;
    do v = 6'($urandom); while (v inside {6'h20, 6'h22, 6'h24, 6'h26});
    return v;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (!reset && sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("state", 32'(bus.state_out), 32'(e.st));
      check("ctl", 32'(ctl_dut()), 32'(e.ctl));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d entries pending", sb_q.size());
    $fatal(1);
  end

  initial begin
    int k;
    logic [5:0] op, fn;
    bus.opcode = 6'h00;
    bus.funct  = 6'h00;
    bus.zero   = 1'b0;
    #1;
    check("reset_state", bus.state_out, 0);
    check("reset_ctl", ctl_dut(), ctl_of(0, 6'h00));
    run_cycles(3);
    reset = 1'b0;

    do_instr(6'h00, 6'h20);
    do_instr(6'h23, 6'h00);
    do_instr(6'h2B, 6'h00);
    do_instr(6'h04, 6'h00);
    do_instr(6'h02, 6'h00);
    do_instr(6'h00, 6'h22);
    do_instr(6'h00, 6'h24);
    do_instr(6'h00, 6'h26);
    do_instr(6'h3F, 6'h00);
    do_instr(6'h00, 6'h21);

    // Abort a load in its first LW_MEM cycle.
    bus.opcode = 6'h23;
    bus.funct  = 6'h00;
    push(0, 6'h00, F);
    push(1, 6'h00, 1);
    push(2, 6'h00, 1);
    push(5, 6'h00, 1);
    push(6, 6'h00, 1);
    run_cycles(F + 3);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("abort_state", bus.state_out, 0);
    check("abort_reg_write", bus.reg_write, 0);
    run_cycles(2);
    reset = 1'b0;
    do_instr(6'h00, 6'h20);

    for (int i = 0; i < 60; i++) begin
      k  = $urandom_range(0, 9);
      fn = fns[$urandom_range(0, 3)];
      case (k)
        0, 1, 2: op = 6'h00;
        3:       op = 6'h23;
        4:       op = 6'h2B;
        5:       op = 6'h04;
        6:       op = 6'h02;
        7:       op = rand_illegal_op();
        8: begin op = 6'h00; fn = rand_illegal_fn(); end
        default: op = ops[$urandom_range(0, 4)];
      endcase
      do_instr(op, fn);
    end

    check("queue_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
